// File: rtl/nonce_job_loader_if.sv
// Byte-serial job-frame write channel from the SPI command decoder into the loader.
// wr_ready is the only return path; a byte moves when wr_valid & wr_ready.
interface nonce_job_loader_if;
  logic       wr_valid;
  logic       wr_sof;
  logic [7:0] wr_byte;
  logic       wr_ready;

  modport master (output wr_valid, output wr_sof, output wr_byte, input wr_ready);
  modport slave  (input wr_valid, input wr_sof, input wr_byte, output wr_ready);
endinterface

// File: rtl/nonce_job_loader.sv
// Assembles 45-byte job frames into two dispatcher slots; commit lands one cycle after the last byte.
// wr_ready drops while a finished frame waits for a free slot (both slots occupied).
module nonce_job_loader #(
  parameter int FRAME_BYTES = 45
) (
  input  logic         clk,
  input  logic         reset_n,
  nonce_job_loader_if.slave wr,
  input  logic         flush,
  input  logic         job_taken,
  output logic [3:0]   hash_id1,
  output logic [3:0]   hash_id2,
  output logic [95:0]  rx_m_data1,
  output logic [95:0]  rx_m_data2,
  output logic [255:0] rx_intial_h1,
  output logic [255:0] rx_intial_h2,
  output logic         mark,
  output logic [1:0]   mark_counter,
  output logic         job_avail,
  output logic         frame_err
);

  localparam int IDX_W  = $clog2(FRAME_BYTES);
  localparam int TAIL_W = (FRAME_BYTES - 1) * 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    S_HUNT,
    S_COLLECT,
    S_PEND
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]  idx;
  logic [3:0]        stg_id;
  logic [TAIL_W-1:0] stg_tail;
  logic              accept;
  logic              pending;
  logic              last_byte;
  logic              frame_err_nxt;

  logic              take;
  logic [1:0]        count_t;
  logic              mark_t;
  logic              commit;
  logic              wr_slot2;
  logic [1:0]        count_nxt;
  logic              mark_nxt;

  assign pending     = (state == S_PEND);
  assign wr.wr_ready = ~pending;
  assign accept      = wr.wr_valid & wr.wr_ready;
  assign last_byte   = (idx == LAST_IDX);
  assign job_avail   = (mark_counter != 2'd0);

  // Take is resolved before commit so a slot freed this cycle is refilled at once.
  always_comb begin
    take     = job_taken & (mark_counter != 2'd0) & ~flush;
    count_t  = mark_counter;
    mark_t   = mark;
    if (take) begin
      if (mark_counter == 2'd2) begin
        count_t = 2'd1;
      end else begin
        count_t = 2'd0;
        mark_t  = 1'b0;
      end
    end
    commit    = pending & ~flush & (count_t != 2'd2);
    wr_slot2  = (count_t == 2'd1) & mark_t;
    count_nxt = count_t;
    mark_nxt  = mark_t;
    if (flush) begin
      count_nxt = 2'd0;
      mark_nxt  = 1'b0;
    end else if (commit) begin
      if (count_t == 2'd0) begin
        count_nxt = 2'd1;
        mark_nxt  = 1'b1;
      end else begin
        count_nxt = 2'd2;
        mark_nxt  = ~mark_t;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    frame_err_nxt = 1'b0;
    if (flush) begin
      state_nxt = S_HUNT;
    end else begin
      case (state)
        S_HUNT: begin
          if (accept && wr.wr_sof) state_nxt = S_COLLECT;
        end
        S_COLLECT: begin
          if (accept) begin
            if (wr.wr_sof) begin
              frame_err_nxt = 1'b1;
            end else if (last_byte) begin
              state_nxt = S_PEND;
            end
          end
        end
        S_PEND: begin
          if (commit) state_nxt = S_HUNT;
        end
        default: state_nxt = S_HUNT;
      endcase
    end
  end

  // Payload bytes shift in big-endian; after 44 shifts byte 1 sits at the top.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx      <= '0;
      stg_id   <= '0;
      stg_tail <= '0;
    end else if (accept && !flush) begin
      if (wr.wr_sof) begin
        idx    <= IDX_W'(1);
        stg_id <= wr.wr_byte[3:0];
      end else if (state == S_COLLECT) begin
        stg_tail <= {stg_tail[TAIL_W-9:0], wr.wr_byte};
        idx      <= last_byte ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hash_id1     <= '0;
      hash_id2     <= '0;
      rx_m_data1   <= '0;
      rx_m_data2   <= '0;
      rx_intial_h1 <= '0;
      rx_intial_h2 <= '0;
    end else if (commit) begin
      if (wr_slot2) begin
        hash_id2     <= stg_id;
        rx_m_data2   <= stg_tail[TAIL_W-1 -: 96];
        rx_intial_h2 <= stg_tail[255:0];
      end else begin
        hash_id1     <= stg_id;
        rx_m_data1   <= stg_tail[TAIL_W-1 -: 96];
        rx_intial_h1 <= stg_tail[255:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mark_counter <= 2'd0;
      mark         <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      mark_counter <= count_nxt;
      mark         <= mark_nxt;
      frame_err    <= frame_err_nxt;
    end
  end

endmodule

// File: doc/nonce_job_loader.md
Name: nonce_job_loader

Overview:
- Producer side of the nonce-core job interface. Assembles job frames arriving byte-serially from the SPI command decoder.
- Stores up to two jobs in slot 1 and slot 2. Publishes the slot-select flags mark and mark_counter to the nonce-core dispatcher.
- Frees a slot when the dispatcher pulses job_taken, which is the dispatcher's start output.
- Guarantees that a slot the dispatcher may still capture is never overwritten.

Parameters:
- FRAME_BYTES, 45, bytes per job frame. Fixed layout: 1 hash_id byte + 12 m_data bytes + 32 midstate bytes.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- wr_valid  in  1  wr_byte is valid this cycle
- wr_sof  in  1  qualifies wr_valid; this byte is byte 0 of a frame
- wr_byte  in  8  frame byte
- wr_ready  out  1  loader accepts a byte this cycle
- flush  in  1  synchronous discard of all jobs (new block / abort)
- job_taken  in  1  one-cycle pulse; dispatcher consumed the oldest job
- hash_id1 / hash_id2  out  4  slot job IDs
- rx_m_data1 / rx_m_data2  out  96  slot message tails
- rx_intial_h1 / rx_intial_h2  out  256  slot midstates
- mark  out  1  slot-order flag (encoding below)
- mark_counter  out  2  number of valid jobs, 0..2
- job_avail  out  1  mark_counter != 0
- frame_err  out  1  one-cycle pulse on a malformed frame

Behaviour:
- Reset (async): idx=0, hunting=1, pending=0, mark_counter=0, mark=0, frame_err=0, all slot registers 0. wr_ready=1 after reset.
- Byte accept: a byte is accepted when wr_valid & wr_ready.
- wr_ready = !pending.
- Frame start: an accepted byte with wr_sof is byte 0. It sets idx=1 and hunting=0, even mid-frame. An abandoned partial frame is dropped and frame_err pulses.
- Hunting: accepted bytes without wr_sof while hunting=1 are discarded silently.
- Byte layout, big-endian, into the staging register:
  - byte0[3:0] -> hash_id; byte0[7:4] is ignored.
  - bytes 1..12 -> m_data[95:0], byte1 = [95:88].
  - bytes 13..44 -> midstate[255:0], byte13 = [255:248].
- Frame completion: accepting byte 44 (idx==FRAME_BYTES-1) sets pending=1 and hunting=1 at that edge.
- Stray trailing bytes after completion without wr_sof are discarded silently (hunting).
- Mark encoding, shared with the dispatcher:
  - count==1: mark=1 means the job is in slot 1; mark=0 means slot 2.
  - count==2: mark=0 means slot 1 is older; mark=1 means slot 2 is older.
  - oldest_is_1 = (count==1 & mark) | (count==2 & !mark).
- Commit (pending=1, evaluated each edge):
  - count==0: write slot 1; count=1, mark=1.
  - count==1: write the empty slot (slot 2 if mark=1, else slot 1); count=2, mark=!mark.
  - count==2: hold; wr_ready stays 0 (backpressure).
- A commit clears pending.
- Latency: byte 44 accepted at edge N. Commit at edge N+1 if a slot is free. Slot data and mark_counter are updated together after edge N+1. wr_ready returns to 1 in the same cycle.
- job_taken:
  - count 2->1: mark unchanged. The remaining job's encoding falls out directly.
  - count 1->0: mark->0.
  - count 0: job_taken is ignored and frame_err is NOT raised.
- job_taken and commit in the same cycle: apply take first, then commit into the freed or free slot.
  - At count==2 the freed slot is the oldest one. It is rewritten with the new job, count stays 2, and mark toggles.
- Flush has the highest priority: count=0, mark=0, pending=0, hunting=1.
  - Slot data registers hold their values; they are don't-care.
  - job_taken in the same cycle is ignored.
- Slot registers change only on commit or reset. A valid slot is never written.

Test Plan:
- Reset, then one frame: byte0=0x05, m_data bytes 0x01..0x0C, midstate bytes 0x20..0x3F, no gaps -> 2 cycles after byte 44: mark_counter=1, mark=1, hash_id1=5, rx_m_data1=0x0102..0C, rx_intial_h1[255:248]=0x20.
- Two frames (IDs 1, 2) -> count=2, mark=0, hash_id2=2. Third frame: wr_ready drops after its byte 44 and stays 0. Pulse job_taken -> slot 1 is rewritten with ID 3 the same cycle, count=2, mark=1.
- count=2, mark=0, job_taken alone -> count=1, mark=0 (slot 2 remains). Second job_taken -> count=0, job_avail=0.
- wr_sof re-asserted at byte 20 -> frame_err pulse for 1 cycle, no commit. The new 45-byte frame commits normally.
- Bytes without wr_sof after reset -> ignored, count stays 0. job_taken at count 0 -> no change.
- count=2 with pending, then flush together with job_taken -> count=0, pending=0, wr_ready=1 next cycle, no commit of the pending job.
